// File: rtl/micro_sequencer.sv
// Microprogram sequencer: owns the control-store address register and steps it
// by Next/Jump/Decode, with memory-wait stall, halt and a committed-word counter.
module micro_sequencer #(
  parameter int ADDR_WIDTH = 11,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                  MSEQ_CLOCK_50,
  input  logic                  MSEQ_RESET_InLow,
  input  logic [1:0]            MSEQ_SEL_IN,
  input  logic [ADDR_WIDTH-1:0] MSEQ_JADDR_IN,
  input  logic [1:0]            MSEQ_IR_OP_IN,
  input  logic [5:0]            MSEQ_IR_OP3_IN,
  input  logic                  MSEQ_STALL_IN,
  input  logic                  MSEQ_HALT_IN,
  output logic [ADDR_WIDTH-1:0] MSEQ_ADDR_OUT,
  output logic                  MSEQ_EXEC_OUT,
  output logic                  MSEQ_HALTED_OUT,
  output logic                  MSEQ_ERR_OUT,
  output logic [CNT_WIDTH-1:0]  MSEQ_CNT_OUT
);

  typedef enum logic [1:0] {ST_INIT, ST_RUN, ST_STALL, ST_HALT} state_t;

  state_t                state, next_state;
  logic [ADDR_WIDTH-1:0] csar, csar_next, decode_addr;
  logic [CNT_WIDTH-1:0]  cnt;
  logic                  err, err_next, halted, exec, commit;

  // Decode target is the opcode-indexed dispatch table in the upper half of the store
  always_comb begin
    decode_addr       = '0;
    decode_addr[10:0] = {1'b1, MSEQ_IR_OP_IN, MSEQ_IR_OP3_IN, 2'b00};
  end

  always_comb begin
    next_state = state;
    csar_next  = csar;
    err_next   = err;
    exec       = 1'b0;
    commit     = 1'b0;
    case (state)
      ST_INIT: next_state = ST_RUN;
      ST_RUN: begin
        exec = !MSEQ_STALL_IN;
        if (MSEQ_HALT_IN) begin
          next_state = ST_HALT;
        end else if (MSEQ_STALL_IN) begin
          next_state = ST_STALL;
        end else begin
          commit = 1'b1;
          case (MSEQ_SEL_IN)
            2'b00:   csar_next = csar + 1'b1;
            2'b01:   csar_next = MSEQ_JADDR_IN;
            2'b10:   csar_next = decode_addr;
            default: err_next  = 1'b1;
          endcase
        end
      end
      ST_STALL: begin
        if (MSEQ_HALT_IN)       next_state = ST_HALT;
        else if (!MSEQ_STALL_IN) next_state = ST_RUN;
      end
      ST_HALT: next_state = ST_HALT;
      default: next_state = ST_INIT;
    endcase
  end

  always_ff @(posedge MSEQ_CLOCK_50 or negedge MSEQ_RESET_InLow) begin
    if (!MSEQ_RESET_InLow) begin
      state  <= ST_INIT;
      csar   <= '0;
      cnt    <= '0;
      err    <= 1'b0;
      halted <= 1'b0;
    end else begin
      state  <= next_state;
      csar   <= csar_next;
      err    <= err_next;
      halted <= (next_state == ST_HALT);
      if (commit) cnt <= cnt + 1'b1;
    end
  end

  assign MSEQ_ADDR_OUT   = csar;
  assign MSEQ_EXEC_OUT   = exec;
  assign MSEQ_HALTED_OUT = halted;
  assign MSEQ_ERR_OUT    = err;
  assign MSEQ_CNT_OUT    = cnt;

endmodule

// File: tb/tb_micro_sequencer.sv
// Bench for micro_sequencer: directed vector table, hand-written corner cases
// and randomized traffic against a behavioural model of the sequencing rules.
module tb_micro_sequencer;

  localparam int AW = 11;
  localparam int CW = 4;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [1:0]    sel = '0;
  logic [AW-1:0] jaddr = '0;
  logic [1:0]    op = '0;
  logic [5:0]    op3 = '0;
  logic          stall = 1'b0;
  logic          halt = 1'b0;
  logic [AW-1:0] addr;
  logic          exec, halted, err;
  logic [CW-1:0] cnt;

  int n_checks = 0;
  int n_pass   = 0;

  // Behavioural model: plain integers and flags following the sequencing rules
  int m_addr, m_cnt;
  bit m_err, m_started, m_waiting, m_halted;

  typedef struct {
    logic [1:0]    sel;
    logic [AW-1:0] jaddr;
    logic [1:0]    op;
    logic [5:0]    op3;
    logic          stall;
    logic          halt;
    logic          exp_exec;
    logic [AW-1:0] exp_addr;
    logic [CW-1:0] exp_cnt;
    logic          exp_err;
  } vec_t;

  vec_t vecs[$];

  micro_sequencer #(.ADDR_WIDTH(AW), .CNT_WIDTH(CW)) dut (
    .MSEQ_CLOCK_50   (clk),
    .MSEQ_RESET_InLow(rst_n),
    .MSEQ_SEL_IN     (sel),
    .MSEQ_JADDR_IN   (jaddr),
    .MSEQ_IR_OP_IN   (op),
    .MSEQ_IR_OP3_IN  (op3),
    .MSEQ_STALL_IN   (stall),
    .MSEQ_HALT_IN    (halt),
    .MSEQ_ADDR_OUT   (addr),
    .MSEQ_EXEC_OUT   (exec),
    .MSEQ_HALTED_OUT (halted),
    .MSEQ_ERR_OUT    (err),
    .MSEQ_CNT_OUT    (cnt)
  );

  always #5 clk = ~clk;

  task automatic checkVal(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  function automatic bit modelExec(input logic st);
    return m_started && !m_halted && !m_waiting && !st;
  endfunction

  task automatic modelReset();
    m_addr = 0; m_cnt = 0; m_err = 0;
    m_started = 0; m_waiting = 0; m_halted = 0;
  endtask

  task automatic modelEdge(input logic [1:0] s, input logic [AW-1:0] j, input logic [1:0] o,
                           input logic [5:0] o3, input logic st, input logic h);
    if (m_halted) return;
    if (!m_started) begin m_started = 1; return; end
    if (h) begin m_halted = 1; m_waiting = 0; return; end
    if (st) begin m_waiting = 1; return; end
    if (m_waiting) begin m_waiting = 0; return; end
    m_cnt = (m_cnt + 1) % (1 << CW);
    case (s)
      2'd0: m_addr = (m_addr + 1) % (1 << AW);
      2'd1: m_addr = int'(j);
      2'd2: m_addr = 1024 + int'(o) * 256 + int'(o3) * 4;
      default: m_err = 1;
    endcase
  endtask

  task automatic applyStimulus(input logic [1:0] s, input logic [AW-1:0] j, input logic [1:0] o,
                               input logic [5:0] o3, input logic st, input logic h);
    sel = s; jaddr = j; op = o; op3 = o3; stall = st; halt = h;
  endtask

  task automatic checkOutput();
    checkVal("addr", addr, m_addr);
    checkVal("cnt", cnt, m_cnt);
    checkVal("err", err, m_err);
    checkVal("halted", halted, m_halted);
  endtask

  task automatic runCycle(input logic [1:0] s, input logic [AW-1:0] j, input logic [1:0] o,
                          input logic [5:0] o3, input logic st, input logic h);
    applyStimulus(s, j, o, o3, st, h);
    #1;
    checkVal("exec", exec, modelExec(st));
    modelEdge(s, j, o, o3, st, h);
    @(posedge clk);
    #1;
    checkOutput();
  endtask

  task automatic randomCycle(input int halt_odds);
    runCycle(2'($urandom_range(0, 3)), AW'($urandom), 2'($urandom), 6'($urandom),
             ($urandom_range(0, 3) == 0), ($urandom_range(0, halt_odds - 1) == 0));
  endtask

  // Reset asserted between edges must clear everything without a clock edge
  task automatic doReset();
    rst_n = 1'b0;
    #2;
    checkVal("rst_addr", addr, 0);
    checkVal("rst_exec", exec, 0);
    checkVal("rst_halted", halted, 0);
    checkVal("rst_err", err, 0);
    checkVal("rst_cnt", cnt, 0);
    modelReset();
    applyStimulus(2'd0, '0, 2'd0, 6'd0, 1'b0, 1'b0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  initial begin
    logic [AW-1:0] frozen_addr;
    logic [CW-1:0] frozen_cnt;

    modelReset();
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) runCycle(2'd0, '0, 2'd0, 6'd0, 1'b0, 1'b0);
    doReset();

    // sel, jaddr, op, op3, stall, halt, exec, addr-after, cnt-after, err-after
    vecs.push_back('{2'd0, 11'h000, 2'd0, 6'd0,  1'b0, 1'b0, 1'b0, 11'h000, 4'd0,  1'b0});
    vecs.push_back('{2'd0, 11'h000, 2'd0, 6'd0,  1'b0, 1'b0, 1'b1, 11'h001, 4'd1,  1'b0});
    vecs.push_back('{2'd0, 11'h000, 2'd0, 6'd0,  1'b0, 1'b0, 1'b1, 11'h002, 4'd2,  1'b0});
    vecs.push_back('{2'd0, 11'h000, 2'd0, 6'd0,  1'b0, 1'b0, 1'b1, 11'h003, 4'd3,  1'b0});
    vecs.push_back('{2'd0, 11'h000, 2'd0, 6'd0,  1'b0, 1'b0, 1'b1, 11'h004, 4'd4,  1'b0});
    vecs.push_back('{2'd0, 11'h000, 2'd0, 6'd0,  1'b0, 1'b0, 1'b1, 11'h005, 4'd5,  1'b0});
    vecs.push_back('{2'd3, 11'h000, 2'd0, 6'd0,  1'b0, 1'b0, 1'b1, 11'h005, 4'd6,  1'b1});
    vecs.push_back('{2'd1, 11'h7FF, 2'd0, 6'd0,  1'b0, 1'b0, 1'b1, 11'h7FF, 4'd7,  1'b1});
    vecs.push_back('{2'd0, 11'h000, 2'd0, 6'd0,  1'b0, 1'b0, 1'b1, 11'h000, 4'd8,  1'b1});
    vecs.push_back('{2'd2, 11'h000, 2'd3, 6'd4,  1'b0, 1'b0, 1'b1, 11'h710, 4'd9,  1'b1});
    vecs.push_back('{2'd1, 11'h010, 2'd0, 6'd0,  1'b0, 1'b0, 1'b1, 11'h010, 4'd10, 1'b1});
    vecs.push_back('{2'd1, 11'h020, 2'd0, 6'd0,  1'b1, 1'b0, 1'b0, 11'h010, 4'd10, 1'b1});
    vecs.push_back('{2'd1, 11'h020, 2'd0, 6'd0,  1'b1, 1'b0, 1'b0, 11'h010, 4'd10, 1'b1});
    vecs.push_back('{2'd1, 11'h020, 2'd0, 6'd0,  1'b1, 1'b0, 1'b0, 11'h010, 4'd10, 1'b1});
    vecs.push_back('{2'd1, 11'h020, 2'd0, 6'd0,  1'b0, 1'b0, 1'b0, 11'h010, 4'd10, 1'b1});
    vecs.push_back('{2'd1, 11'h020, 2'd0, 6'd0,  1'b0, 1'b0, 1'b1, 11'h020, 4'd11, 1'b1});
    vecs.push_back('{2'd0, 11'h000, 2'd2, 6'd0,  1'b0, 1'b0, 1'b1, 11'h021, 4'd12, 1'b1});
    vecs.push_back('{2'd2, 11'h000, 2'd2, 6'd0,  1'b0, 1'b0, 1'b1, 11'h600, 4'd13, 1'b1});

    foreach (vecs[i]) begin
      applyStimulus(vecs[i].sel, vecs[i].jaddr, vecs[i].op, vecs[i].op3, vecs[i].stall, vecs[i].halt);
      #1;
      checkVal($sformatf("vec%0d_exec", i), exec, vecs[i].exp_exec);
      modelEdge(vecs[i].sel, vecs[i].jaddr, vecs[i].op, vecs[i].op3, vecs[i].stall, vecs[i].halt);
      @(posedge clk);
      #1;
      checkVal($sformatf("vec%0d_addr", i), addr, vecs[i].exp_addr);
      checkVal($sformatf("vec%0d_cnt", i), cnt, vecs[i].exp_cnt);
      checkVal($sformatf("vec%0d_err", i), err, vecs[i].exp_err);
      checkVal($sformatf("vec%0d_halted", i), halted, 0);
    end

    // Illegal select while stalled must not flag an error
    doReset();
    runCycle(2'd0, '0, 2'd0, 6'd0, 1'b0, 1'b0);
    runCycle(2'd3, '0, 2'd0, 6'd0, 1'b1, 1'b0);
    runCycle(2'd3, '0, 2'd0, 6'd0, 1'b1, 1'b0);
    runCycle(2'd3, '0, 2'd0, 6'd0, 1'b0, 1'b0);
    runCycle(2'd0, '0, 2'd0, 6'd0, 1'b0, 1'b0);
    checkVal("err_stall_illegal", err, 0);

    // Halt in RUN together with stall and illegal select: halt wins, no error
    doReset();
    runCycle(2'd0, '0, 2'd0, 6'd0, 1'b0, 1'b0);
    runCycle(2'd0, '0, 2'd0, 6'd0, 1'b0, 1'b0);
    runCycle(2'd3, '0, 2'd0, 6'd0, 1'b1, 1'b1);
    checkVal("halt_run_halted", halted, 1);
    checkVal("halt_run_err", err, 0);

    // Halt from STALL, then activity must not move anything
    doReset();
    runCycle(2'd0, '0, 2'd0, 6'd0, 1'b0, 1'b0);
    runCycle(2'd0, '0, 2'd0, 6'd0, 1'b0, 1'b0);
    runCycle(2'd0, '0, 2'd0, 6'd0, 1'b0, 1'b0);
    runCycle(2'd1, 11'h055, 2'd0, 6'd0, 1'b1, 1'b0);
    runCycle(2'd1, 11'h055, 2'd0, 6'd0, 1'b1, 1'b1);
    checkVal("halt_stall_halted", halted, 1);
    frozen_addr = addr;
    frozen_cnt  = cnt;
    checkVal("halt_stall_addr", frozen_addr, 2);
    for (int i = 0; i < 6; i++) randomCycle(2);
    checkVal("halt_frozen_addr", addr, 2);
    checkVal("halt_frozen_cnt", cnt, 2);
    checkVal("halt_frozen_exec", exec, 0);

    // Counter wraps at 2^CW: 17 commits leave a count of 1
    doReset();
    runCycle(2'd0, '0, 2'd0, 6'd0, 1'b0, 1'b0);
    for (int i = 0; i < 17; i++) runCycle(2'd0, '0, 2'd0, 6'd0, 1'b0, 1'b0);
    checkVal("cnt_wrap", cnt, 1);
    checkVal("cnt_wrap_addr", addr, 17);

    for (int blk = 0; blk < 6; blk++) begin
      doReset();
      for (int i = 0; i < 150; i++) randomCycle(60);
    end

    $display("[TB] %0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
